btb_predict_ctrl: RTL

- Branch target buffer and 2-bit saturating-counter controller that feeds PREDICTOR's history input and owns the predictor state table.
- IF stage looks up by PC; EX stage writes back resolved branch outcomes.
- Sequences table initialisation after reset, then services one lookup and one update per cycle.
- Direct-mapped table, registered prediction outputs.

---
 rtl/btb_predict_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/btb_predict_ctrl.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, an init sweep after reset,
// and registered predictions. Optional macro BTB_BYPASS_EN forwards a same-index update into the lookup.
module btb_predict_ctrl #(
  parameter int         ENTRIES  = 16,
  parameter int         IDX_W    = 4,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [1:0]  pred_history,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        ready
);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep;

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [31:0]      tbl_target [ENTRIES];
  logic [1:0]       tbl_cnt    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             unused_pc_bits;

  assign if_idx         = if_pc[IDX_W+1:2];
  assign if_tag         = if_pc[31:IDX_W+2];
  assign ex_idx         = ex_pc[IDX_W+1:2];
  assign ex_tag         = ex_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Next contents of the entry addressed by the EX update.
  logic             ex_hit, upd_we;
  logic [TAG_W-1:0] upd_tag;
  logic [31:0]      upd_target;
  logic [1:0]       upd_cnt;

  always_comb begin
    ex_hit     = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
    upd_we     = 1'b0;
    upd_tag    = tbl_tag[ex_idx];
    upd_target = tbl_target[ex_idx];
    upd_cnt    = tbl_cnt[ex_idx];
    if (state == RUN && ex_valid) begin
      if (ex_hit) begin
        upd_we = 1'b1;
        if (ex_taken) begin
          upd_cnt    = (tbl_cnt[ex_idx] == 2'b11) ? 2'b11 : tbl_cnt[ex_idx] + 2'b01;
          upd_target = ex_target;
        end else begin
          upd_cnt = (tbl_cnt[ex_idx] == 2'b00) ? 2'b00 : tbl_cnt[ex_idx] - 2'b01;
        end
      end else if (ex_taken) begin
        upd_we     = 1'b1;
        upd_tag    = ex_tag;
        upd_target = ex_target;
        upd_cnt    = 2'b10;
      end
    end
  end

  logic             look_valid, look_hit;
  logic [TAG_W-1:0] look_tag;
  logic [31:0]      look_target;
  logic [1:0]       look_cnt;

  always_comb begin
    look_valid  = tbl_valid[if_idx];
    look_tag    = tbl_tag[if_idx];
    look_target = tbl_target[if_idx];
    look_cnt    = tbl_cnt[if_idx];
`ifdef BTB_BYPASS_EN
    // Only an update that actually writes is forwarded.
    if (upd_we && (ex_idx == if_idx)) begin
      look_valid  = 1'b1;
      look_tag    = upd_tag;
      look_target = upd_target;
      look_cnt    = upd_cnt;
    end
`endif
    look_hit = (state == RUN) && look_valid && (look_tag == if_tag);
  end

  // Table storage has no reset; the INIT sweep establishes every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        tbl_valid[sweep]  <= 1'b0;
        tbl_tag[sweep]    <= '0;
        tbl_target[sweep] <= '0;
        tbl_cnt[sweep]    <= INIT_CNT;
      end else if (upd_we) begin
        tbl_valid[ex_idx]  <= 1'b1;
        tbl_tag[ex_idx]    <= upd_tag;
        tbl_target[ex_idx] <= upd_target;
        tbl_cnt[ex_idx]    <= upd_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      sweep        <= '0;
      ready        <= 1'b0;
      pred_valid   <= 1'b0;
      pred_hit     <= 1'b0;
      pred_taken   <= 1'b0;
      pred_history <= 2'b00;
      pred_target  <= 32'h0;
    end else begin
      ready <= (state == RUN);
      case (state)
        INIT: begin
          sweep <= sweep + 1'b1;
          if (sweep == IDX_W'(ENTRIES - 1)) state <= RUN;
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
      pred_valid <= if_valid;
      if (if_valid) begin
        pred_hit     <= look_hit;
        pred_taken   <= look_hit && look_cnt[1];
        pred_history <= look_hit ? look_cnt : 2'b00;
        pred_target  <= look_hit ? look_target : 32'h0;
      end
    end
  end
endmodule
